// File: rtl/fft_overflow_monitor.sv
// Block-floating-point overflow monitor for one FFT transform: counts guard-bit
// violations per stage and issues the per-stage rescale events at each stage end.
module fft_overflow_monitor #(
    parameter int DATA_WIDTH  = 16,
    parameter int GUARD_BITS  = 1,
    parameter int STAGE_WIDTH = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          fft_start_i,
    input  logic [STAGE_WIDTH-1:0]        num_stages_i,
    input  logic                          auto_scale_en_i,
    input  logic                          sample_valid_i,
    output logic                          sample_ready_o,
    input  logic signed [DATA_WIDTH-1:0]  sample_real_i,
    input  logic signed [DATA_WIDTH-1:0]  sample_imag_i,
    input  logic                          sample_last_i,
    output logic                          stage_complete_o,
    output logic                          scale_factor_increment_o,
    output logic                          overflow_detected_o,
    output logic [7:0]                    overflow_magnitude_o,
    output logic [STAGE_WIDTH-1:0]        overflow_stage_o,
    output logic                          scale_next_stage_o,
    output logic                          busy_o,
    output logic                          done_o
);

    typedef enum logic [1:0] {IDLE, MONITOR, REPORT, DONE} state_t;

    state_t                 state;
    logic [STAGE_WIDTH-1:0] stage_idx;
    logic [STAGE_WIDTH-1:0] num_stages_q;
    logic [7:0]             ovf_cnt;
    logic                   accept;
    logic                   sample_ovf;
    logic                   last_stage;

    // Arithmetic shift leaves only the sign plus guard bits; anything other than
    // all-zeros or all-ones means the headroom has been consumed.
    function automatic logic has_ovf(input logic signed [DATA_WIDTH-1:0] x);
        logic signed [DATA_WIDTH-1:0] sh;
        sh = x >>> (DATA_WIDTH - 1 - GUARD_BITS);
        return !((sh == '0) || (sh == '1));
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

    assign sample_ready_o = (state == MONITOR);
    assign accept         = sample_valid_i & sample_ready_o;
    assign sample_ovf     = has_ovf(sample_real_i) | has_ovf(sample_imag_i);
    assign last_stage     = (stage_idx == num_stages_q - STAGE_WIDTH'(1));

    // Event pulses are decoded straight from the state register so they line up
    // with the single REPORT/DONE cycle.
    assign stage_complete_o         = (state == REPORT);
    assign overflow_detected_o      = (state == REPORT) && (ovf_cnt != 8'd0);
    assign scale_factor_increment_o = overflow_detected_o && auto_scale_en_i;
    assign done_o                   = (state == DONE);
    assign busy_o                   = (state != IDLE);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state                <= IDLE;
            stage_idx            <= '0;
            num_stages_q         <= '0;
            ovf_cnt              <= 8'd0;
            overflow_magnitude_o <= 8'd0;
            overflow_stage_o     <= '0;
            scale_next_stage_o   <= 1'b0;
        end else if (fft_start_i) begin
            // Restart wins over everything, including a sample offered this cycle.
            stage_idx          <= '0;
            ovf_cnt            <= 8'd0;
            scale_next_stage_o <= 1'b0;
            num_stages_q       <= num_stages_i;
            state              <= (num_stages_i == '0) ? DONE : MONITOR;
        end else begin
            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                MONITOR: begin
                    if (accept) begin
                        if (sample_ovf) begin
                            ovf_cnt <= sat_inc(ovf_cnt);
                        end
                        if (sample_last_i) begin
                            state <= REPORT;
                        end
                    end
                end
                REPORT: begin
                    overflow_magnitude_o <= ovf_cnt;
                    overflow_stage_o     <= stage_idx;
                    scale_next_stage_o   <= (ovf_cnt != 8'd0) && auto_scale_en_i;
                    ovf_cnt              <= 8'd0;
                    if (last_stage) begin
                        state <= DONE;
                    end else begin
                        stage_idx <= stage_idx + STAGE_WIDTH'(1);
                        state     <= MONITOR;
                    end
                end
                DONE: begin
                    scale_next_stage_o <= 1'b0;
                    state              <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_overflow_monitor.sv
// Scoreboard bench for fft_overflow_monitor: expected stage reports are queued as
// samples are driven and matched against the stage_complete_o events.
module tb_fft_overflow_monitor;

    logic               clk_i = 1'b0;
    logic               reset_n_i = 1'b0;
    logic               fft_start_i = 1'b0;
    logic [7:0]         num_stages_i = 8'd0;
    logic               auto_scale_en_i = 1'b0;
    logic               sample_valid_i = 1'b0;
    logic               sample_ready_o;
    logic signed [15:0] sample_real_i = 16'sd0;
    logic signed [15:0] sample_imag_i = 16'sd0;
    logic               sample_last_i = 1'b0;
    logic               stage_complete_o;
    logic               scale_factor_increment_o;
    logic               overflow_detected_o;
    logic [7:0]         overflow_magnitude_o;
    logic [7:0]         overflow_stage_o;
    logic               scale_next_stage_o;
    logic               busy_o;
    logic               done_o;

    fft_overflow_monitor #(.DATA_WIDTH(16), .GUARD_BITS(1), .STAGE_WIDTH(8)) dut (
        .clk_i                    (clk_i),
        .reset_n_i                (reset_n_i),
        .fft_start_i              (fft_start_i),
        .num_stages_i             (num_stages_i),
        .auto_scale_en_i          (auto_scale_en_i),
        .sample_valid_i           (sample_valid_i),
        .sample_ready_o           (sample_ready_o),
        .sample_real_i            (sample_real_i),
        .sample_imag_i            (sample_imag_i),
        .sample_last_i            (sample_last_i),
        .stage_complete_o         (stage_complete_o),
        .scale_factor_increment_o (scale_factor_increment_o),
        .overflow_detected_o      (overflow_detected_o),
        .overflow_magnitude_o     (overflow_magnitude_o),
        .overflow_stage_o         (overflow_stage_o),
        .scale_next_stage_o       (scale_next_stage_o),
        .busy_o                   (busy_o),
        .done_o                   (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int stg;
        int mag;
        bit det;
        bit inc;
    } rpt_t;

    rpt_t sb[$];
    rpt_t pend;
    bit   pend_v = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // With one guard bit a 16-bit value overflows when bits 15 and 14 differ.
    function automatic bit ovf16(input logic [15:0] v);
        return v[15] != v[14];
    endfunction

    // Report pulses are checked in the REPORT cycle; the registered report
    // fields and the scale level one cycle later.
    always @(negedge clk_i) begin
        if (!reset_n_i) begin
            pend_v = 1'b0;
        end else begin
            if (pend_v) begin
                check("ovf_magnitude", overflow_magnitude_o, pend.mag);
                check("ovf_stage", overflow_stage_o, pend.stg);
                check("scale_next", scale_next_stage_o, pend.inc);
                pend_v = 1'b0;
            end
            if (stage_complete_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_stage_complete", 1, 0);
                end else begin
                    pend = sb.pop_front();
                    check("ovf_detected", overflow_detected_o, pend.det);
                    check("scale_increment", scale_factor_increment_o, pend.inc);
                    pend_v = 1'b1;
                end
            end
        end
    end

    task automatic start_fft(input int nst, input bit with_sample);
        fft_start_i    = 1'b1;
        num_stages_i   = 8'(nst);
        sample_valid_i = with_sample;
        sample_real_i  = 16'sh4000;
        sample_imag_i  = 16'sh8000;
        sample_last_i  = with_sample;
        @(posedge clk_i); #1;
        fft_start_i    = 1'b0;
        sample_valid_i = 1'b0;
        sample_last_i  = 1'b0;
    endtask

    // Drives n samples (first novf use the overflow pattern) and queues the report.
    task automatic do_stage(input int stg, input int n, input int novf,
                            input logic [15:0] re_o, input logic [15:0] im_o,
                            input bit with_last);
        int cnt = 0;
        for (int i = 0; i < n; i++) begin
            sample_valid_i = 1'b1;
            sample_real_i  = (i < novf) ? re_o : 16'h0100;
            sample_imag_i  = (i < novf) ? im_o : 16'h0100;
            sample_last_i  = with_last && (i == n - 1);
            if (ovf16(sample_real_i) || ovf16(sample_imag_i)) cnt++;
            if (with_last && i == n - 1) begin
                sb.push_back('{stg: stg, mag: (cnt > 255) ? 255 : cnt,
                               det: cnt != 0, inc: (cnt != 0) && auto_scale_en_i});
            end
            @(posedge clk_i); #1;
        end
        sample_valid_i = 1'b0;
        sample_last_i  = 1'b0;
        if (with_last) begin
            @(posedge clk_i); #1;
        end
    endtask

    task automatic expect_done();
        check("done_pulse", done_o, 1);
        check("busy_in_done", busy_o, 1);
        @(posedge clk_i); #1;
        check("done_cleared", done_o, 0);
        check("idle_not_busy", busy_o, 0);
        check("scale_after_done", scale_next_stage_o, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_busy", busy_o, 0);
        check("rst_ready", sample_ready_o, 0);
        check("rst_magnitude", overflow_magnitude_o, 0);
        check("rst_done", done_o, 0);
        @(posedge clk_i); #1;
        reset_n_i = 1'b1;
        @(posedge clk_i); #1;

        // T1: three clean stages
        auto_scale_en_i = 1'b1;
        start_fft(3, 1'b0);
        check("t1_ready", sample_ready_o, 1);
        for (int s = 0; s < 3; s++) do_stage(s, 4, 0, 16'h0, 16'h0, 1'b1);
        expect_done();

        // T2: stage 1 overflows with auto scaling enabled
        start_fft(3, 1'b0);
        do_stage(0, 4, 0, 16'h0, 16'h0, 1'b1);
        do_stage(1, 4, 2, 16'h4000, 16'h0100, 1'b1);
        check("t2_scale_stage2", scale_next_stage_o, 1);
        do_stage(2, 2, 0, 16'h0, 16'h0, 1'b0);
        check("t2_scale_mid_stage2", scale_next_stage_o, 1);
        do_stage(2, 2, 0, 16'h0, 16'h0, 1'b1);
        expect_done();

        // T3: same overflow, auto scaling disabled
        auto_scale_en_i = 1'b0;
        start_fft(3, 1'b0);
        do_stage(0, 4, 0, 16'h0, 16'h0, 1'b1);
        do_stage(1, 4, 2, 16'h4000, 16'h0100, 1'b1);
        check("t3_scale_stage2", scale_next_stage_o, 0);
        do_stage(2, 4, 0, 16'h0, 16'h0, 1'b1);
        expect_done();

        // T4: count saturates at 255
        auto_scale_en_i = 1'b1;
        start_fft(1, 1'b0);
        do_stage(0, 300, 300, 16'h0100, 16'h8000, 1'b1);
        expect_done();

        // T5: abort mid-stage, restart with an overflowing last sample in the start cycle
        start_fft(2, 1'b0);
        do_stage(0, 2, 2, 16'h4000, 16'h0100, 1'b0);
        check("t5_busy_mid", busy_o, 1);
        start_fft(2, 1'b1);
        check("t5_restart_ready", sample_ready_o, 1);
        do_stage(0, 3, 0, 16'h0, 16'h0, 1'b1);
        do_stage(1, 3, 0, 16'h0, 16'h0, 1'b1);
        expect_done();

        // T6: zero stages goes straight to DONE
        start_fft(0, 1'b0);
        check("t6_no_complete", stage_complete_o, 0);
        expect_done();

        // Reset mid-MONITOR after a scaling report
        start_fft(2, 1'b0);
        do_stage(0, 3, 3, 16'h4000, 16'h0100, 1'b1);
        sample_valid_i = 1'b1;
        sample_real_i  = 16'sh4000;
        @(posedge clk_i); #1;
        reset_n_i = 1'b0;
        #1;
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_ready", sample_ready_o, 0);
        check("mid_rst_magnitude", overflow_magnitude_o, 0);
        check("mid_rst_stage", overflow_stage_o, 0);
        check("mid_rst_scale", scale_next_stage_o, 0);
        sample_valid_i = 1'b0;
        @(posedge clk_i); #1;
        reset_n_i = 1'b1;
        @(posedge clk_i); #1;
        check("post_rst_busy", busy_o, 0);
        check("post_rst_complete", stage_complete_o, 0);

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
